// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush controller for the five-stage pipeline: load-use, shared-RAM conflict, jumps and slow-device wait states.
// Optional statistics counters are built when PIPE_HAZARD_STAT_EN is defined.
module pipe_hazard_ctrl #(
  parameter int WAIT_CYCLES = 3
) (
  input  logic        clk_50MHz,
  input  logic        rst,
  input  logic        id_USE_A,
  input  logic        id_USE_B,
  input  logic [3:0]  id_SRC_A,
  input  logic [3:0]  id_SRC_B,
  input  logic        ie_LOAD,
  input  logic        ie_WB_EN,
  input  logic [3:0]  ie_WB_ADDR,
  input  logic        ie_JUMP,
  input  logic        em_INST_RAM,
  input  logic        em_SLOW,
  output logic        pc_PAUSE,
  output logic        ii_PAUSE,
  output logic        ie_PAUSE,
  output logic        em_PAUSE,
  output logic        ii_FLUSH,
  output logic        ie_FLUSH,
  output logic        mw_FLUSH,
  output logic        mem_DONE,
  output logic [15:0] stall_cnt,
  output logic [15:0] flush_cnt
);

  localparam logic [3:0] CNT_INIT = 4'(WAIT_CYCLES - 1);

  typedef enum logic [0:0] {
    RUN  = 1'b0,
    WAIT = 1'b1
  } state_t;

  state_t     state;
  logic [3:0] cnt;
  logic       load_use;

  assign load_use = ie_LOAD & ie_WB_EN &
                    ((id_USE_A & (id_SRC_A == ie_WB_ADDR)) |
                     (id_USE_B & (id_SRC_B == ie_WB_ADDR)));

  always_ff @(posedge clk_50MHz) begin
    if (!rst) begin
      state <= RUN;
      cnt   <= 4'd0;
    end else begin
      case (state)
        RUN: begin
          if (em_SLOW) begin
            state <= WAIT;
            cnt   <= CNT_INIT;
          end else begin
            state <= RUN;
            cnt   <= 4'd0;
          end
        end
        WAIT: begin
          // em_SLOW is deliberately ignored here: the release cycle always returns to RUN
          if (cnt != 4'd0) begin
            state <= WAIT;
            cnt   <= cnt - 4'd1;
          end else begin
            state <= RUN;
            cnt   <= 4'd0;
          end
        end
        default: begin
          state <= RUN;
          cnt   <= 4'd0;
        end
      endcase
    end
  end

  always_comb begin
    pc_PAUSE = 1'b0;
    ii_PAUSE = 1'b0;
    ie_PAUSE = 1'b0;
    em_PAUSE = 1'b0;
    ii_FLUSH = 1'b0;
    ie_FLUSH = 1'b0;
    mw_FLUSH = 1'b0;
    mem_DONE = 1'b0;
    if (!rst) begin
      ii_FLUSH = 1'b1;
      ie_FLUSH = 1'b1;
      mw_FLUSH = 1'b1;
    end else begin
      case (state)
        WAIT: begin
          if (cnt != 4'd0) begin
            pc_PAUSE = 1'b1;
            ii_PAUSE = 1'b1;
            ie_PAUSE = 1'b1;
            em_PAUSE = 1'b1;
            mw_FLUSH = 1'b1;
          end else begin
            mem_DONE = 1'b1;
          end
        end
        RUN: begin
          // Slow entry freezes everything; jump beats load-use, load-use beats RAM conflict
          if (em_SLOW) begin
            pc_PAUSE = 1'b1;
            ii_PAUSE = 1'b1;
            ie_PAUSE = 1'b1;
            em_PAUSE = 1'b1;
            mw_FLUSH = 1'b1;
          end else if (ie_JUMP) begin
            ii_FLUSH = 1'b1;
            ie_FLUSH = 1'b1;
          end else if (load_use) begin
            pc_PAUSE = 1'b1;
            ii_PAUSE = 1'b1;
            ie_FLUSH = 1'b1;
          end else if (em_INST_RAM) begin
            pc_PAUSE = 1'b1;
            ii_FLUSH = 1'b1;
          end else begin
            pc_PAUSE = 1'b0;
          end
        end
        default: begin
          pc_PAUSE = 1'b0;
        end
      endcase
    end
  end

`ifdef PIPE_HAZARD_STAT_EN
  always_ff @(posedge clk_50MHz) begin
    if (!rst) begin
      stall_cnt <= 16'h0000;
      flush_cnt <= 16'h0000;
    end else begin
      if (pc_PAUSE && (stall_cnt != 16'hFFFF)) begin
        stall_cnt <= stall_cnt + 16'h0001;
      end else begin
        stall_cnt <= stall_cnt;
      end
      if ((ii_FLUSH || ie_FLUSH) && (flush_cnt != 16'hFFFF)) begin
        flush_cnt <= flush_cnt + 16'h0001;
      end else begin
        flush_cnt <= flush_cnt;
      end
    end
  end
`else
  assign stall_cnt = 16'h0000;
  assign flush_cnt = 16'h0000;
`endif

endmodule

// File: doc/pipe_hazard_ctrl.md
# pipe_hazard_ctrl

Central stall/flush controller for the five-stage pipeline. It watches the ID, EXE and MEM stages and drives the PAUSE and FLUSH inputs of the PC register and the IF/ID, ID/EXE, EXE/MEM and MEM/WB pipeline registers. It resolves load-use hazards, the shared instruction/data RAM conflict, taken jumps, and multi-cycle slow-device accesses. The slow-device case is handled by a wait-state FSM.

## Interface
- WAIT_CYCLES, 3, pipeline-wide pause length for a slow-device (serial/flash) access; legal range 1..15.
- clk_50MHz  in  1  system clock; all state updates on the rising edge.
- rst  in  1  reset, synchronous, active-low.
- id_USE_A, id_USE_B  in  1 each  ID instruction reads source A / source B.
- id_SRC_A, id_SRC_B  in  4 each  ID source register codes (R0–R7, SP, IH, RA, T).
- ie_LOAD  in  1  EXE instruction is a RAM read.
- ie_WB_EN  in  1  EXE instruction writes a register.
- ie_WB_ADDR  in  4  EXE destination register code.
- ie_JUMP  in  1  EXE resolved a taken jump/branch this cycle.
- em_INST_RAM  in  1  MEM stage accesses the RAM shared with instruction fetch.
- em_SLOW  in  1  MEM stage accesses a slow device.
- pc_PAUSE, ii_PAUSE, ie_PAUSE, em_PAUSE  out  1 each  hold the PC / IF-ID / ID-EXE / EXE-MEM register (1 = `PAUSE_ENABLE`).
- ii_FLUSH, ie_FLUSH, mw_FLUSH  out  1 each  load a bubble (all ops = NOP, write disabled) into IF-ID / ID-EXE / MEM-WB.
- mem_DONE  out  1  one-cycle pulse on the slow-access release cycle.
- stall_cnt, flush_cnt  out  16 each  statistics counters (see Configuration).

## Operation
- FSM states: RUN, WAIT. A 4-bit counter `cnt` is used only in WAIT.
- Load-use hazard: asserted when `ie_LOAD & ie_WB_EN` is high and a used ID source equals `ie_WB_ADDR`.
- Outputs in RUN are combinational from the inputs. The priority order, highest first, is:
  1. **Slow entry** (em_SLOW=1):
     - pc/ii/ie/em_PAUSE=1 and mw_FLUSH=1.
     - `cnt` ← WAIT_CYCLES−1; next state WAIT.
     - Jump, load-use and RAM conflict are ignored; they are re-evaluated after release because the stage contents are frozen.
  2. **Jump** (ie_JUMP=1):
     - ii_FLUSH=1, ie_FLUSH=1, all pauses 0 so the PC loads the target.
     - Overrides load-use (the ID instruction is wrong-path) and RAM conflict (the blocked fetch is wrong-path).
  3. **Load-use:**
     - pc_PAUSE=1, ii_PAUSE=1, ie_FLUSH=1.
     - If em_INST_RAM is also high, ii_PAUSE wins over the conflict flush.
  4. **RAM conflict** (em_INST_RAM=1): pc_PAUSE=1, ii_FLUSH=1.
  5. Otherwise all outputs are 0.
- WAIT state:
  - cnt≠0: all four pauses = 1, mw_FLUSH=1, cnt−1.
  - cnt=0: all outputs 0 except mem_DONE=1; next state RUN. em_SLOW is not sampled in this cycle.
- A PAUSE and a FLUSH never target the same register in the same cycle.

## Timing
- Reset (rst=0 at an edge) forces:
  - state=RUN, cnt=0.
  - While rst is low, outputs are ii_FLUSH=ie_FLUSH=mw_FLUSH=1 and every other output 0, including mem_DONE and pc_PAUSE. This fills the pipeline with bubbles.
- Reset asserted during WAIT aborts the wait; no mem_DONE is issued.
- Load-use, jump and conflict responses take effect at the same edge: 0 cycles of latency, with exactly one bubble/hold cycle per event.
- Slow access:
  - Pauses are high for exactly WAIT_CYCLES consecutive cycles, starting with the entry cycle.
  - mem_DONE follows on the next cycle.
  - The slow instruction occupies MEM for WAIT_CYCLES+1 cycles.
- Back-to-back slow accesses: the release cycle advances the pipeline, and the next RUN cycle may re-enter WAIT immediately.

## Configuration
- `PIPE_HAZARD_STAT_EN` defined:
  - stall_cnt increments on every cycle where pc_PAUSE=1.
  - flush_cnt increments on every cycle where ii_FLUSH|ie_FLUSH=1.
  - Both counters saturate at 16'hFFFF and are cleared by reset.
- `PIPE_HAZARD_STAT_EN` undefined: no counter logic is built; stall_cnt and flush_cnt are tied to 16'h0000.

## Test plan
- After reset release with no events: ie_LOAD=1, ie_WB_EN=1, ie_WB_ADDR=4'h3, id_USE_A=1, id_SRC_A=4'h3 → that cycle pc_PAUSE=ii_PAUSE=ie_FLUSH=1; next cycle with ie_LOAD=0 → all 0.
- Load-use plus em_INST_RAM=1 in the same cycle → pc_PAUSE=ii_PAUSE=ie_FLUSH=1, ii_FLUSH=0.
- ie_JUMP=1 together with load-use and em_INST_RAM → ii_FLUSH=ie_FLUSH=1, all pauses 0.
- WAIT_CYCLES=3, em_SLOW=1 for one edge and ie_JUMP=1 held → pauses high for 3 cycles, mem_DONE on the 4th cycle, jump flush only on the 5th cycle; with WAIT_CYCLES=1 → 1 pause cycle, then mem_DONE.
- rst=0 on the 2nd WAIT cycle → next cycle RUN, all pauses 0, mem_DONE never pulses, FLUSH outputs high while rst=0.
- With `PIPE_HAZARD_STAT_EN`: 5 load-use cycles plus 2 jumps → stall_cnt=5, flush_cnt=7. Preloaded near 16'hFFFF, stall_cnt holds at 16'hFFFF. Without the macro → both counters read 0.
